bomb_countdown_ctrl: RTL and testbench



---
 rtl/bomb_pkg.sv | 25 ++
 rtl/bomb_sec_tick.sv | 38 +++
 rtl/bomb_countdown_ctrl.sv | 114 +++++++++++
 tb/tb_bomb_countdown_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bomb_pkg.sv
`default_nettype none
// ============================================================
// bomb_pkg : shared states, widths and defaults for the bomb game
// Revision : 1.0
// ============================================================
package bomb_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ARMED    = 2'd1,
      DEFUSED  = 2'd2,
      EXPLODED = 2'd3
   } state_t;

   localparam int SEC_W    = 7;
   localparam int STRIKE_W = 3;

   localparam int DEF_CLK_PER_SEC = 1000;
   localparam int DEF_START_SEC   = 60;
   localparam int DEF_WARN_SEC    = 10;
   localparam int DEF_PENALTY_SEC = 5;
   localparam int DEF_MAX_STRIKES = 3;

endpackage
`default_nettype wire

// File: rtl/bomb_sec_tick.sv
`default_nettype none
// ============================================================
// bomb_sec_tick : clock prescaler giving a once-per-second wrap and half-second phase
// Revision : 1.0
// ============================================================
module bomb_sec_tick #(
   parameter int CLK_PER_SEC = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clear,
   output logic wrap,
   output logic phase
);

   localparam int PW = (CLK_PER_SEC > 2) ? $clog2(CLK_PER_SEC) : 1;
   localparam logic [PW-1:0] LAST = PW'(CLK_PER_SEC - 1);
   localparam logic [PW-1:0] HALF = PW'(CLK_PER_SEC / 2);

   logic [PW-1:0] count;

   // clear wins over en so the counter can be parked at zero
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (en) begin
         count <= (count == LAST) ? '0 : count + PW'(1);
      end
   end

   assign wrap  = en && (count == LAST);
   assign phase = (count < HALF);

endmodule
`default_nettype wire

// File: rtl/bomb_countdown_ctrl.sv
`default_nettype none
// ============================================================
// bomb_countdown_ctrl : arm / countdown / penalty / defuse game-state controller
// Revision : 1.0
// ============================================================
module bomb_countdown_ctrl
   import bomb_pkg::*;
#(
   parameter int CLK_PER_SEC = DEF_CLK_PER_SEC,
   parameter int START_SEC   = DEF_START_SEC,
   parameter int WARN_SEC    = DEF_WARN_SEC,
   parameter int PENALTY_SEC = DEF_PENALTY_SEC,
   parameter int MAX_STRIKES = DEF_MAX_STRIKES
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                code_ok,
   input  logic                code_bad,
   output logic                bomb,
   output logic                defused,
   output logic                u10,
   output logic                LSB,
   output logic                sec,
   output logic [SEC_W-1:0]    remaining,
   output logic [STRIKE_W-1:0] strikes
);

   localparam logic [SEC_W-1:0]    START_V = SEC_W'(START_SEC);
   localparam logic [SEC_W-1:0]    WARN_V  = SEC_W'(WARN_SEC);
   localparam logic [7:0]          PEN_V   = 8'(PENALTY_SEC);
   localparam logic [STRIKE_W-1:0] MAX_V   = STRIKE_W'(MAX_STRIKES);

   state_t              state, state_next;
   logic [SEC_W-1:0]    rem_next;
   logic [STRIKE_W-1:0] str_next;
   logic [STRIKE_W-1:0] str_inc;
   logic [7:0]          rem_wide;
   logic [SEC_W-1:0]    penalized;
   logic                tick_wrap;
   logic                tick_phase;

   bomb_sec_tick #(
      .CLK_PER_SEC (CLK_PER_SEC)
   ) u_tick (
      .clk   (clk),
      .rst   (rst),
      .en    (state == ARMED),
      .clear (state_next != ARMED),
      .wrap  (tick_wrap),
      .phase (tick_phase)
   );

   // penalty saturates at zero; 8-bit headroom keeps the subtraction from wrapping
   assign rem_wide  = {1'b0, remaining};
   assign penalized = (rem_wide > PEN_V) ? SEC_W'(rem_wide - PEN_V) : '0;
   assign str_inc   = strikes + STRIKE_W'(1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         remaining <= START_V;
         strikes   <= '0;
      end else begin
         state     <= state_next;
         remaining <= rem_next;
         strikes   <= str_next;
      end
   end

   always_comb begin
      state_next = state;
      rem_next   = remaining;
      str_next   = strikes;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = ARMED;
               rem_next   = START_V;
               str_next   = '0;
            end
         end
         ARMED: begin
            if (code_ok) begin
               state_next = DEFUSED;
            end else if (code_bad) begin
               str_next = str_inc;
               rem_next = penalized;
               if ((penalized == '0) || (str_inc == MAX_V)) begin
                  state_next = EXPLODED;
               end
            end else if (tick_wrap) begin
               if (remaining <= SEC_W'(1)) begin
                  rem_next   = '0;
                  state_next = EXPLODED;
               end else begin
                  rem_next = remaining - SEC_W'(1);
               end
            end
         end
         default: begin
            state_next = state;
         end
      endcase
   end

   assign bomb    = (state == EXPLODED);
   assign defused = (state == DEFUSED);
   assign u10     = (state == ARMED) && (remaining < WARN_V);
   assign LSB     = remaining[0];
   assign sec     = (state == ARMED) && tick_phase;

endmodule
`default_nettype wire

// File: tb/tb_bomb_countdown_ctrl.sv
`default_nettype none
// ============================================================
// tb_bomb_countdown_ctrl : directed self-checking bench for bomb_countdown_ctrl
// Revision : 1.0
// ============================================================
module tb_bomb_countdown_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0, code_ok = 1'b0, code_bad = 1'b0;
   logic       bomb, defused, u10, lsb, sec;
   logic [6:0] rem;
   logic [2:0] strikes;

   logic       start2 = 1'b0, code_ok2 = 1'b0, code_bad2 = 1'b0;
   logic       bomb2, defused2, u10_2, lsb2, sec2;
   logic [6:0] rem2;
   logic [2:0] strikes2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bomb_countdown_ctrl #(
      .CLK_PER_SEC (4),
      .START_SEC   (12),
      .WARN_SEC    (10),
      .PENALTY_SEC (5),
      .MAX_STRIKES (3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .code_ok   (code_ok),
      .code_bad  (code_bad),
      .bomb      (bomb),
      .defused   (defused),
      .u10       (u10),
      .LSB       (lsb),
      .sec       (sec),
      .remaining (rem),
      .strikes   (strikes)
   );

   bomb_countdown_ctrl #(
      .CLK_PER_SEC (4),
      .START_SEC   (60),
      .WARN_SEC    (10),
      .PENALTY_SEC (5),
      .MAX_STRIKES (3)
   ) dut60 (
      .clk       (clk),
      .rst       (rst),
      .start     (start2),
      .code_ok   (code_ok2),
      .code_bad  (code_bad2),
      .bomb      (bomb2),
      .defused   (defused2),
      .u10       (u10_2),
      .LSB       (lsb2),
      .sec       (sec2),
      .remaining (rem2),
      .strikes   (strikes2)
   );

   // the two terminal indications must never be seen together
   always @(negedge clk) begin
      if (rst) begin
         assert (!(bomb && defused) && !(bomb2 && defused2))
         else begin
            bad++;
            $display("FAIL exclusive got bomb=%b defused=%b bomb2=%b defused2=%b want not both",
                     bomb, defused, bomb2, defused2);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      start = 1'b0; code_ok = 1'b0; code_bad = 1'b0;
      start2 = 1'b0; code_ok2 = 1'b0; code_bad2 = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
   endtask

   task automatic arm();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // {bomb, defused, u10, sec, lsb}
   task automatic test_reset();
      do_reset();
      total++;
      if ({bomb, defused, u10, sec, lsb} !== 5'b00000) begin
         bad++;
         $display("FAIL reset_flags got=%b want=00000", {bomb, defused, u10, sec, lsb});
      end
      total++;
      if ({rem, strikes} !== {7'd12, 3'd0}) begin
         bad++;
         $display("FAIL reset_counts got rem=%0d str=%0d want rem=12 str=0", rem, strikes);
      end
      tick();
      total++;
      if ({bomb, defused, u10, sec, rem} !== {4'b0000, 7'd12}) begin
         bad++;
         $display("FAIL idle_hold got flags=%b rem=%0d want 0000 rem=12",
                  {bomb, defused, u10, sec}, rem);
      end
   endtask

   task automatic test_timeout();
      int exp_rem;
      int sec_high;
      logic exp_u10, exp_sec, exp_bomb;
      do_reset();
      arm();
      total++;
      if ({rem, sec, u10} !== {7'd12, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL arm_state got rem=%0d sec=%b u10=%b want rem=12 sec=1 u10=0", rem, sec, u10);
      end
      sec_high = 0;
      for (int i = 1; i <= 48; i++) begin
         tick();
         exp_rem  = 12 - i / 4;
         exp_bomb = (i == 48);
         exp_sec  = !exp_bomb && ((i % 4) < 2);
         exp_u10  = !exp_bomb && (exp_rem < 10);
         if (i >= 4 && i < 8) sec_high += int'(sec);
         total++;
         if ({rem, bomb, sec, u10, lsb} !== {7'(exp_rem), exp_bomb, exp_sec, exp_u10, 1'(exp_rem % 2)}) begin
            bad++;
            $display("FAIL timeout_c%0d got rem=%0d bomb=%b sec=%b u10=%b lsb=%b want rem=%0d bomb=%b sec=%b u10=%b",
                     i, rem, bomb, sec, u10, lsb, exp_rem, exp_bomb, exp_sec, exp_u10);
         end
      end
      total++;
      if (sec_high !== 2) begin
         bad++;
         $display("FAIL sec_duty got=%0d want=2", sec_high);
      end
      repeat (3) tick();
      total++;
      if ({rem, bomb, defused, sec} !== {7'd0, 3'b100}) begin
         bad++;
         $display("FAIL exploded_hold got rem=%0d bomb=%b def=%b sec=%b want 0 1 0 0",
                  rem, bomb, defused, sec);
      end
   endtask

   task automatic test_penalty();
      do_reset();
      arm();
      code_bad = 1'b1;
      tick();
      total++;
      if ({rem, strikes, bomb} !== {7'd7, 3'd1, 1'b0}) begin
         bad++;
         $display("FAIL pen1 got rem=%0d str=%0d bomb=%b want 7 1 0", rem, strikes, bomb);
      end
      tick();
      code_bad = 1'b0;
      total++;
      if ({rem, strikes, bomb} !== {7'd2, 3'd2, 1'b0}) begin
         bad++;
         $display("FAIL pen2 got rem=%0d str=%0d bomb=%b want 2 2 0", rem, strikes, bomb);
      end
      code_bad = 1'b1;
      tick();
      code_bad = 1'b0;
      total++;
      if ({rem, strikes, bomb} !== {7'd0, 3'd3, 1'b1}) begin
         bad++;
         $display("FAIL pen_sat got rem=%0d str=%0d bomb=%b want 0 3 1", rem, strikes, bomb);
      end
   endtask

   task automatic test_bad_on_wrap();
      do_reset();
      arm();
      repeat (3) tick();
      code_bad = 1'b1;
      tick();
      code_bad = 1'b0;
      total++;
      if ({rem, strikes} !== {7'd7, 3'd1}) begin
         bad++;
         $display("FAIL bad_wrap got rem=%0d str=%0d want 7 1", rem, strikes);
      end
      repeat (3) tick();
      total++;
      if (rem !== 7'd7) begin
         bad++;
         $display("FAIL bad_wrap_phase got rem=%0d want 7", rem);
      end
      tick();
      total++;
      if (rem !== 7'd6) begin
         bad++;
         $display("FAIL bad_wrap_next got rem=%0d want 6", rem);
      end
   endtask

   task automatic test_strike_limit();
      do_reset();
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      total++;
      if (rem2 !== 7'd60) begin
         bad++;
         $display("FAIL strike_arm got rem=%0d want 60", rem2);
      end
      code_bad2 = 1'b1;
      tick();
      tick();
      total++;
      if ({rem2, strikes2, bomb2} !== {7'd50, 3'd2, 1'b0}) begin
         bad++;
         $display("FAIL strike2 got rem=%0d str=%0d bomb=%b want 50 2 0", rem2, strikes2, bomb2);
      end
      tick();
      code_bad2 = 1'b0;
      total++;
      if ({rem2, strikes2, bomb2} !== {7'd45, 3'd3, 1'b1}) begin
         bad++;
         $display("FAIL strike3 got rem=%0d str=%0d bomb=%b want 45 3 1", rem2, strikes2, bomb2);
      end
   endtask

   task automatic test_defuse_race();
      do_reset();
      arm();
      repeat (47) tick();
      total++;
      if (rem !== 7'd1) begin
         bad++;
         $display("FAIL race_pre got rem=%0d want 1", rem);
      end
      code_ok = 1'b1;
      tick();
      code_ok = 1'b0;
      total++;
      if ({defused, bomb, rem, sec} !== {2'b10, 7'd1, 1'b0}) begin
         bad++;
         $display("FAIL race got def=%b bomb=%b rem=%0d sec=%b want 1 0 1 0", defused, bomb, rem, sec);
      end
      start = 1'b1; tick(); start = 1'b0;
      code_bad = 1'b1; tick(); code_bad = 1'b0;
      code_ok = 1'b1; tick(); code_ok = 1'b0;
      repeat (5) tick();
      total++;
      if ({defused, bomb, rem, strikes, sec, u10} !== {2'b10, 7'd1, 3'd0, 2'b00}) begin
         bad++;
         $display("FAIL defused_frozen got def=%b bomb=%b rem=%0d str=%0d sec=%b u10=%b want 1 0 1 0 0 0",
                  defused, bomb, rem, strikes, sec, u10);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      arm();
      repeat (16) tick();
      code_ok  = 1'b1;
      code_bad = 1'b1;
      tick();
      code_ok  = 1'b0;
      code_bad = 1'b0;
      total++;
      if ({defused, bomb, rem, strikes} !== {2'b10, 7'd8, 3'd0}) begin
         bad++;
         $display("FAIL ok_and_bad got def=%b bomb=%b rem=%0d str=%0d want 1 0 8 0",
                  defused, bomb, rem, strikes);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      arm();
      repeat (28) tick();
      total++;
      if ({rem, u10, sec} !== {7'd5, 2'b11}) begin
         bad++;
         $display("FAIL pre_rst got rem=%0d u10=%b sec=%b want 5 1 1", rem, u10, sec);
      end
      #2;
      rst = 1'b0;
      #1;
      total++;
      if ({bomb, defused, u10, sec, lsb, rem, strikes} !== {5'b00000, 7'd12, 3'd0}) begin
         bad++;
         $display("FAIL async_rst got flags=%b rem=%0d str=%0d want 00000 12 0",
                  {bomb, defused, u10, sec, lsb}, rem, strikes);
      end
      tick();
      rst = 1'b1;
      code_bad = 1'b1;
      tick();
      code_bad = 1'b0;
      tick();
      total++;
      if ({rem, strikes, sec, bomb} !== {7'd12, 3'd0, 2'b00}) begin
         bad++;
         $display("FAIL idle_ignore got rem=%0d str=%0d sec=%b bomb=%b want 12 0 0 0",
                  rem, strikes, sec, bomb);
      end
      arm();
      tick();
      total++;
      if ({rem, sec} !== {7'd12, 1'b1}) begin
         bad++;
         $display("FAIL rearm got rem=%0d sec=%b want 12 1", rem, sec);
      end
   endtask

   initial begin
      test_reset();
      test_timeout();
      test_penalty();
      test_bad_on_wrap();
      test_strike_limit();
      test_defuse_race();
      test_back_to_back();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
